// File: rtl/ps2_pkg.sv
// PS/2 host transmitter shared types and constants.
// Holds the FSM encoding, error codes and command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    WAIT_ACK,
    WAIT_IDLE,
    ERR
  } ps2_state_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_START_TMO = 2'd1;
  localparam logic [1:0] ERR_FRAME_TMO = 2'd2;
  localparam logic [1:0] ERR_NO_ACK    = 2'd3;

  localparam logic [7:0] CMD_LED   = 8'hED;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] CMD_ECHO  = 8'hEE;

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic longint unsigned us_to_cyc(
    input int unsigned hz,
    input int unsigned us
  );
    return (64'(hz) * 64'(us)) / 64'd1_000_000;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 line.
// Also keeps the previous synced level for falling-edge detect.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic fall
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  // idle bus is pulled high, so reset to 1 to avoid a fake edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= line_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign fall  = prev_q & ~s2_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Drives PS2CLK/PS2Data open-drain through output enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned INHIBIT_US   = 100,
  parameter int unsigned START_TMO_US = 15000,
  parameter int unsigned FRAME_TMO_US = 2000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] TxData,
  input  logic       TxValid,
  output logic       TxReady,
  input  logic       PS2CLK_in,
  input  logic       PS2Data_in,
  output logic       PS2CLK_oe,
  output logic       PS2Data_oe,
  output logic       Busy,
  output logic       Done,
  output logic       Err,
  output logic [1:0] ErrCode
);

  localparam longint unsigned INH_CYC =
    us_to_cyc(CLK_HZ, INHIBIT_US);
  localparam longint unsigned START_CYC =
    us_to_cyc(CLK_HZ, START_TMO_US);
  localparam longint unsigned FRAME_CYC =
    us_to_cyc(CLK_HZ, FRAME_TMO_US);

  localparam longint unsigned MAX_A =
    (INH_CYC > START_CYC) ? INH_CYC : START_CYC;
  localparam longint unsigned MAX_CYC =
    (MAX_A > FRAME_CYC) ? MAX_A : FRAME_CYC;

  localparam int TW =
    (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // loads are count-1 so each state lasts exactly count cycles
  localparam logic [TW-1:0] INH_LD   = TW'(INH_CYC - 1);
  localparam logic [TW-1:0] START_LD = TW'(START_CYC - 1);
  localparam logic [TW-1:0] FRAME_LD = TW'(FRAME_CYC - 1);

  logic clk_lvl;
  logic clk_fall;
  logic dat_lvl;
  logic unused_dat_fall;

  ps2_line_sync u_clk_sync (
    .clk     (CLK),
    .rst_n   (RST_N),
    .line_in (PS2CLK_in),
    .level   (clk_lvl),
    .fall    (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk     (CLK),
    .rst_n   (RST_N),
    .line_in (PS2Data_in),
    .level   (dat_lvl),
    .fall    (unused_dat_fall)
  );

  ps2_state_t    state_q;
  ps2_state_t    state_d;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic [3:0]    bitcnt_q;
  logic [3:0]    bitcnt_d;
  logic [8:0]    frame_q;
  logic [8:0]    frame_d;
  logic [1:0]    code_q;
  logic [1:0]    code_d;
  logic          tmo;
  logic          clk_oe;
  logic          dat_oe;
  logic          done;

  assign tmo = (timer_q == '0);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      frame_q  <= '0;
      code_q   <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      frame_q  <= frame_d;
      code_q   <= code_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = tmo ? '0 : timer_q - 1'b1;
    bitcnt_d = bitcnt_q;
    frame_d  = frame_q;
    code_d   = code_q;
    clk_oe   = 1'b0;
    dat_oe   = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (TxValid) begin
          state_d  = INHIBIT;
          frame_d  = {odd_par(TxData), TxData};
          bitcnt_d = '0;
          timer_d  = INH_LD;
        end
      end
      INHIBIT: begin
        clk_oe = 1'b1;
        if (tmo) begin
          state_d = RTS;
          timer_d = START_LD;
        end
      end
      RTS: begin
        dat_oe = 1'b1;
        if (clk_fall) begin
          state_d  = SEND;
          bitcnt_d = '0;
          timer_d  = FRAME_LD;
        end else if (tmo) begin
          state_d = ERR;
          code_d  = ERR_START_TMO;
        end
      end
      SEND: begin
        dat_oe = ~frame_q[bitcnt_q];
        if (tmo) begin
          state_d = ERR;
          code_d  = ERR_FRAME_TMO;
        end else if (clk_fall) begin
          if (bitcnt_q == 4'd8) begin
            state_d = WAIT_ACK;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        if (tmo) begin
          state_d = ERR;
          code_d  = ERR_FRAME_TMO;
        end else if (clk_fall) begin
          if (!dat_lvl) begin
            state_d = WAIT_IDLE;
          end else begin
            state_d = ERR;
            code_d  = ERR_NO_ACK;
          end
        end
      end
      WAIT_IDLE: begin
        if (tmo) begin
          state_d = ERR;
          code_d  = ERR_FRAME_TMO;
        end else if (clk_lvl && dat_lvl) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign TxReady    = (state_q == IDLE);
  assign Busy       = ~TxReady;
  assign Done       = done;
  assign Err        = (state_q == ERR);
  assign ErrCode    = Err ? code_q : ERR_NONE;
  assign PS2CLK_oe  = clk_oe;
  assign PS2Data_oe = dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device.
// Device clocks at 12.5 kHz (80 cycles of the 1 MHz system clock).
module tb_ps2_host_tx;

  localparam int HALF = 40;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       clk_oe;
  logic       dat_oe;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic       dev_clk_low;
  logic       dev_dat_low;
  logic       ps2c;
  logic       ps2d;

  assign ps2c = ~(clk_oe | dev_clk_low);
  assign ps2d = ~(dat_oe | dev_dat_low);

  ps2_host_tx #(
    .CLK_HZ       (1_000_000),
    .INHIBIT_US   (100),
    .START_TMO_US (15000),
    .FRAME_TMO_US (2000)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .TxData     (tx_data),
    .TxValid    (tx_valid),
    .TxReady    (tx_ready),
    .PS2CLK_in  (ps2c),
    .PS2Data_in (ps2d),
    .PS2CLK_oe  (clk_oe),
    .PS2Data_oe (dat_oe),
    .Busy       (busy),
    .Done       (done),
    .Err        (err),
    .ErrCode    (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic [1:0] last_code = 2'd0;
  int unsigned cyc = 0;
  int unsigned fall_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) begin
      err_cnt++;
      last_code = err_code;
    end
    if (done && err) both_cnt++;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~b;
  endtask

  task automatic dev_frame(
    input  int          nclk,
    input  bit          ack,
    output logic [10:0] w
  );
    int t;
    w = '0;
    t = 0;
    while (!(ps2c && !ps2d) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("rts_seen", 32'(t < 2000), 32'd1);
    repeat (20) @(negedge clk);
    w[0] = ps2d;
    for (int i = 0; i < nclk; i++) begin
      if (i == 10 && ack) begin
        dev_dat_low = 1'b1;
        repeat (10) @(negedge clk);
      end
      if (i == 0) fall_cyc = cyc;
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i < 10) w[i+1] = ps2d;
      repeat (HALF) @(negedge clk);
      if (i == 10) dev_dat_low = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (!tx_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(t < 5000), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [10:0] w;
    int d0;
    int e0;
    int n;
    int unsigned dt;

    rst_n       = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs",
      {tx_ready, busy, done, err, err_code, clk_oe, dat_oe},
      8'b1000_0000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: 0xED with ack, inhibit length, latched byte
    start_tx(8'hED);
    check("inhibit_outs", {busy, tx_ready, clk_oe, dat_oe}, 4'b1010);
    n = 0;
    while (clk_oe && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("inhibit_len", n, 100);
    check("rts_outs", {clk_oe, dat_oe}, 2'b01);
    d0 = done_cnt;
    e0 = err_cnt;
    dev_frame(11, 1'b1, w);
    wait_idle("idle_ed");
    check("bits_ed", w, 11'b11_1110_1101_0);
    check("done_ed", done_cnt - d0, 1);
    check("noerr_ed", err_cnt - e0, 0);

    // 2: parity 0 and parity 1 cases
    start_tx(8'h01);
    d0 = done_cnt;
    dev_frame(11, 1'b1, w);
    wait_idle("idle_01");
    check("bits_01", w, 11'b10_0000_0001_0);
    check("par_01", 32'(^w[9:1]), 32'd1);
    check("done_01", done_cnt - d0, 1);
    start_tx(8'h00);
    d0 = done_cnt;
    dev_frame(11, 1'b1, w);
    wait_idle("idle_00");
    check("bits_00", w, 11'b11_0000_0000_0);
    check("done_00", done_cnt - d0, 1);

    // 3: device never clocks
    start_tx(8'hEE);
    n = 0;
    while (!(dat_oe && !clk_oe) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rts_wait3", 32'(n < 1000), 32'd1);
    n = 0;
    while (!err && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("start_tmo_len", n, 15000);
    check("start_tmo_code", err_code, 2'd1);
    check("start_tmo_rel", {clk_oe, dat_oe, done}, 3'b000);
    @(negedge clk);
    check("start_tmo_rdy", tx_ready, 1'b1);

    // 4: no ack
    start_tx(8'hED);
    d0 = done_cnt;
    e0 = err_cnt;
    dev_frame(11, 1'b0, w);
    check("noack_err", err_cnt - e0, 1);
    check("noack_code", last_code, 2'd3);
    check("noack_nodone", done_cnt - d0, 0);
    check("noack_rdy", tx_ready, 1'b1);
    check("noack_bits", w, 11'b11_1110_1101_0);

    // 5: device stops after 4 clocks
    start_tx(8'hED);
    dev_frame(4, 1'b0, w);
    n = 0;
    while (!err && n < 3000) begin
      @(negedge clk);
      n++;
    end
    dt = cyc - fall_cyc;
    check("frame_tmo_seen", 32'(n < 3000), 32'd1);
    check("frame_tmo_lat", 32'(dt >= 2001 && dt <= 2005), 32'd1);
    check("frame_tmo_code", err_code, 2'd2);
    check("frame_tmo_rel", {clk_oe, dat_oe}, 2'b00);
    wait_idle("idle_tmo");

    // 6: reset during SEND at bitcnt 5, then 0xFF
    start_tx(8'hED);
    dev_frame(6, 1'b0, w);
    check("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid", {clk_oe, dat_oe, busy, tx_ready}, 4'b0001);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    start_tx(8'hFF);
    d0 = done_cnt;
    dev_frame(11, 1'b1, w);
    wait_idle("idle_ff");
    check("bits_ff", w, 11'b11_1111_1111_0);
    check("done_ff", done_cnt - d0, 1);

    check("done_err_excl", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
